imem_boot_loader: RTL

- Upstream of the single-cycle core: fills instruction memory from a 32-bit valid/ready word stream, then releases the core from reset.
- Holds the core in reset until a length-prefixed, XOR-checksummed program image has been written completely and verified.
- Sits between a host/UART word stream and the instruction memory write port. Drives the core's active-low reset.

---
 rtl/imem_boot_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed image from a valid/ready word stream into instruction memory.
// Write latency 1 cycle after each payload handshake; ready only while loading (LEN/LOAD/CHK), core held in reset until verified.
module imem_boot_loader #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [31:0]       i_s_data,
    input  logic              i_restart,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [31:0]       o_wdata,
    output logic              o_core_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LEN_W = $clog2(DEPTH_WORDS) + 1;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_LOAD = 3'd1,
        S_CHK  = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len;
    logic [IDX_W-1:0] idx;
    logic [31:0]      csum;
    logic             hs;
    logic             last;
    logic             len_ok;
    logic             busy_nxt;
    logic             done_nxt;
    logic             err_nxt;

    assign o_s_ready = i_rst_n & ((state == S_LEN) | (state == S_LOAD) | (state == S_CHK));
    assign hs        = i_s_valid & o_s_ready;
    assign last      = (LEN_W'(idx) == (len - LEN_W'(1)));
    assign len_ok    = (i_s_data != 32'd0) && (i_s_data <= 32'(DEPTH_WORDS));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LEN:   if (hs) state_nxt = len_ok ? S_LOAD : S_ERR;
            S_LOAD:  if (hs && last) state_nxt = S_CHK;
            S_CHK:   if (hs) state_nxt = (i_s_data == csum) ? S_RUN : S_ERR;
            S_RUN,
            S_ERR:   if (i_restart) state_nxt = S_LEN;
            default: state_nxt = S_LEN;
        endcase
    end

    // Status flags are decoded from the next state so they flip together with the state register.
    always_comb begin
        busy_nxt = (state_nxt == S_LEN) || (state_nxt == S_LOAD) || (state_nxt == S_CHK);
        done_nxt = (state_nxt == S_RUN);
        err_nxt  = (state_nxt == S_ERR);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_LEN;
            len          <= '0;
            idx          <= '0;
            csum         <= '0;
            o_we         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_core_rst_n <= 1'b0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_we         <= 1'b0;
            o_busy       <= busy_nxt;
            o_done       <= done_nxt;
            o_err        <= err_nxt;
            o_core_rst_n <= done_nxt;
            unique case (state)
                S_LEN: begin
                    if (hs && len_ok) begin
                        len  <= i_s_data[LEN_W-1:0];
                        idx  <= '0;
                        csum <= '0;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        o_we    <= 1'b1;
                        o_waddr <= ADDR_W'({idx, 2'b00});
                        o_wdata <= i_s_data;
                        csum    <= csum ^ i_s_data;
                        // Hold on the final word so a full-depth image never wraps the index.
                        if (!last) idx <= idx + IDX_W'(1);
                    end
                end
                S_RUN,
                S_ERR: begin
                    if (i_restart) begin
                        idx  <= '0;
                        csum <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
